// File: rtl/vga_scan_gen.sv
// VGA raster source for the ball thrower display.
// Generates 640x480@60 timing from the system clock, exports the scan position
// and a per-frame update tick to the renderer, and registers the final RGB,
// sync and blank outputs one pixel behind the counters.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GROUND_Y = 445
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ball,
  output logic [9:0] xCount,
  output logic [9:0] yCount,
  output logic       update,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  // CLK_DIV must be at least 2 so the renderer has a clock to register ball
  // before the pixel stage samples it.
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] GROUND   = 10'(GROUND_Y);

  localparam logic [23:0] RGB_BALL   = 24'hFFFFFF;
  localparam logic [23:0] RGB_GROUND = 24'h008000;
  localparam logic [23:0] RGB_SKY    = 24'h000040;

  logic [DIV_W-1:0] divider;
  logic             pix_en;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             in_hsync;
  logic             in_vsync;
  logic             visible;
  logic [23:0]      rgb_next;
  logic [23:0]      rgb;

  // Next scan position: x wraps at the end of the line and carries into y.
  always_comb begin
    pix_en = (divider == DIV_LAST);
    x_next = xCount + 10'd1;
    y_next = yCount;
    if (xCount == H_LAST) begin
      x_next = '0;
      y_next = (yCount == V_LAST) ? '0 : yCount + 10'd1;
    end
  end

  // Decode the current position into sync, blank and colour for the pixel stage.
  always_comb begin
    in_hsync = (xCount >= HS_START) && (xCount < HS_END);
    in_vsync = (yCount >= VS_START) && (yCount < VS_END);
    visible  = (xCount < H_VIS) && (yCount < V_VIS);
    rgb_next = '0;
    if (visible) begin
      if (ball)
        rgb_next = RGB_BALL;
      else if (yCount >= GROUND)
        rgb_next = RGB_GROUND;
      else
        rgb_next = RGB_SKY;
    end
  end

  // Pixel clock divider: one pix_en pulse every CLK_DIV system clocks.
  always_ff @(posedge clk) begin
    if (rst)
      divider <= '0;
    else if (pix_en)
      divider <= '0;
    else
      divider <= divider + DIV_W'(1);
  end

  // Scan counters plus the update flop, which is high for exactly the line at
  // V_ACTIVE and only changes at line wraps so the renderer sees clean edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      xCount <= '0;
      yCount <= '0;
      update <= 1'b0;
    end else if (pix_en) begin
      xCount <= x_next;
      yCount <= y_next;
      update <= (y_next == V_VIS);
    end
  end

  // Output stage: captures the decoded pixel, so it trails the counters by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      rgb     <= '0;
    end else if (pix_en) begin
      hsync   <= ~in_hsync;
      vsync   <= ~in_vsync;
      blank_n <= visible;
      rgb     <= rgb_next;
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule
